pc_sequencer: RTL

Parametrised program-counter sequencer for the instruction-fetch stage of the teaching processor. It launches one of NPROG programs on Start handshakes and holds the PC until a program is launched. It supports absolute jumps, conditional signed-relative branches, and an optional call/return stack. It also reports run/done status to the test bench.

---
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: Start-handshake program launch, jumps, relative branches.
// Optional return-address stack built only when PC_RAS_EN is defined.
module pc_sequencer #(
  parameter int unsigned A         = 10,
  parameter int unsigned NPROG     = 3,
  parameter int unsigned STRIDE    = 100,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Halt,
  input  logic                       BranchAbs,
  input  logic                       BranchRel,
  input  logic                       ALU_flag,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic [A-1:0]               Target,
  output logic [A-1:0]               ProgCtr,
  output logic [$clog2(NPROG+1)-1:0] ProgIdx,
  output logic                       Running,
  output logic                       Done,
  output logic                       RasErr
);

  localparam int unsigned IdxW = $clog2(NPROG + 1);
  localparam int unsigned CntW = $clog2(NPROG + 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [A-1:0]      pc_q, pc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_r_q;
  logic              rise, fall, launch;
  logic [31:0]       base_full;

`ifdef PC_RAS_EN
  localparam int unsigned PtrW  = $clog2(RAS_DEPTH + 1);
  localparam int unsigned AddrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [A-1:0]      ras_mem [RAS_DEPTH];
  logic [PtrW-1:0]   ras_ptr_q;
  logic              ras_err_q, ras_err_d;
  logic              ras_push, ras_pop, ras_flush, ras_full, ras_empty;
  logic [AddrW-1:0]  ras_top;

  assign ras_full  = (ras_ptr_q == PtrW'(RAS_DEPTH));
  assign ras_empty = (ras_ptr_q == '0);
  assign ras_top   = AddrW'(ras_ptr_q - 1'b1);
`else
  logic unused_ras;
  assign unused_ras = Call ^ Ret;
`endif

  assign rise   = Start & ~start_r_q;
  assign fall   = ~Start & start_r_q;
  // Only falls that close pulses 1..NPROG launch; the saturated count is never a slot.
  assign launch = fall && (cnt_q != '0) && (cnt_q <= CntW'(NPROG));

  always_comb begin
    cnt_d = cnt_q;
    if (rise && (cnt_q != CntW'(NPROG + 1))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    base_full = (32'(cnt_q) - 32'd1) * STRIDE;
`ifdef PC_RAS_EN
    ras_err_d = ras_err_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_flush = 1'b0;
`endif
    if (launch) begin
      pc_d    = base_full[A-1:0];
      idx_d   = IdxW'(cnt_q);
      state_d = StRun;
`ifdef PC_RAS_EN
      ras_flush = 1'b1;
`endif
    end else if (state_q == StRun) begin
      if (Halt) begin
        state_d = StDone;
`ifdef PC_RAS_EN
      end else if (Ret) begin
        if (ras_empty) begin
          pc_d      = pc_q + 1'b1;
          ras_err_d = 1'b1;
        end else begin
          pc_d    = ras_mem[ras_top];
          ras_pop = 1'b1;
        end
      end else if (Call) begin
        pc_d = Target;
        if (ras_full) begin
          ras_err_d = 1'b1;
        end else begin
          ras_push = 1'b1;
        end
`endif
      end else if (BranchAbs) begin
        pc_d = Target;
      end else if (BranchRel && ALU_flag) begin
        // Two's-complement add modulo 2^A gives the signed-relative target.
        pc_d = pc_q + Target;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      start_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      start_r_q <= Start;
    end
  end

`ifdef PC_RAS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ras_ptr_q <= '0;
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= ras_err_d;
      if (ras_flush) begin
        ras_ptr_q <= '0;
      end else if (ras_push) begin
        ras_ptr_q <= ras_ptr_q + 1'b1;
      end else if (ras_pop) begin
        ras_ptr_q <= ras_ptr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && ras_push) begin
      ras_mem[AddrW'(ras_ptr_q)] <= pc_q + 1'b1;
    end
  end

  assign RasErr = ras_err_q;
`else
  assign RasErr = 1'b0;
`endif

  assign ProgCtr = pc_q;
  assign ProgIdx = idx_q;
  assign Running = (state_q == StRun);
  assign Done    = (state_q == StDone);

endmodule
